coin_accumulator: RTL and testbench
===================================

# coin_accumulator

Front-end credit collector for the soda vending datapath. Accepts one coin pulse per cycle (5/10/25 cents), keeps a running deposit, and when the deposit reaches the price it presents `deposit_o` with a one-cycle `exceed_o` strobe to the dispensing stage. That stage turns the strobe into `soda_o` and a change code. The block also handles cancel/refund and rejects coins that arrive when they cannot be credited.

## Interface
- `PRICE`, default 20: vend price in cents. Must be a multiple of 5 and at least 5, with `PRICE + 20 <= 63`.
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_ni`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk_i`.
- `nickel_i`  in  1  5-cent coin pulse, one cycle per coin.
- `dime_i`  in  1  10-cent coin pulse.
- `quarter_i`  in  1  25-cent coin pulse.
- `cancel_i`  in  1  refund request pulse.
- `deposit_o`  out  6  current credit in cents (unsigned).
- `exceed_o`  out  1  vend strobe, high for exactly one cycle.
- `coin_reject_o`  out  1  one-cycle pulse: the coin offered in the previous cycle was not credited.
- `refund_o`  out  1  one-cycle pulse: the credit is being returned.
- `refund_amt_o`  out  6  amount refunded; valid only while `refund_o` is high, 0 otherwise.

## Operation
- States: IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND (credit >= PRICE).
- A valid coin is exactly one of `nickel_i`/`dime_i`/`quarter_i` high. Two or three high at once is invalid: no credit, `coin_reject_o` pulses.
- IDLE or COLLECT, valid coin, no cancel:
  - credit = credit + value, computed on 6 bits; no overflow is possible because max credit = PRICE - 5 + 25.
  - If the new credit >= PRICE, go to VEND; otherwise go to or stay in COLLECT.
- COLLECT with `cancel_i`:
  - `refund_o` = 1 and `refund_amt_o` = current credit for one cycle.
  - Credit clears to 0; go to IDLE.
  - A coin in the same cycle is rejected (`coin_reject_o` = 1).
- IDLE with `cancel_i`: no effect. No refund pulse; a coin in the same cycle is credited normally.
- VEND, one cycle only:
  - `exceed_o` = 1 and `deposit_o` holds the final credit (PRICE .. PRICE+20).
  - Any coin is rejected and `cancel_i` is ignored.
  - Next state is IDLE with credit 0.
- Change seen downstream is `deposit_o - PRICE`, one of {0, 5, 10, 15, 20}.
- Reset values: state IDLE, `deposit_o` = 0, `exceed_o` = 0, `coin_reject_o` = 0, `refund_o` = 0, `refund_amt_o` = 0.
- Reset dominates all inputs. A reset in COLLECT or VEND discards the credit with no refund pulse and no `exceed_o`.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Coin sampled at edge N: `deposit_o` shows the new credit after edge N, so latency is 1 cycle.
- The coin that reaches PRICE at edge N: `exceed_o` = 1 and `deposit_o` = final credit during cycle N+1, both changing on the same edge. The dispensing stage samples them at edge N+2.
- After edge N+2: `exceed_o` = 0 and `deposit_o` = 0; the block accepts coins again from cycle N+2.
- `coin_reject_o`, `refund_o` and `refund_amt_o` pulse in the cycle after the offending or cancel input, for exactly 1 cycle.
- On refund, `deposit_o` reads 0 in the same cycle that `refund_o` is high.
- Back-to-back coins in consecutive cycles are all credited; no idle cycle is needed between coins.

## Test plan
- Reset, then dime, nickel, nickel on consecutive cycles:
  - `deposit_o` steps 10, 15, 20.
  - `exceed_o` is high only in the cycle where `deposit_o` = 20.
  - Next cycle `deposit_o` = 0 and `exceed_o` = 0.
- Dime, nickel, quarter:
  - `deposit_o` reaches 40 with `exceed_o` = 1 (change 20).
  - A nickel offered during that VEND cycle gives `coin_reject_o` = 1 on the next cycle and credit stays 0.
- Nickel, dime, then cancel:
  - `refund_o` = 1 with `refund_amt_o` = 15 and `deposit_o` = 0.
  - Cancel again from IDLE: no `refund_o`.
- `nickel_i` and `dime_i` high together from IDLE:
  - `coin_reject_o` = 1 and `deposit_o` stays 0.
  - Then a single quarter: `deposit_o` = 25 with `exceed_o` = 1.
- Nickel, dime, then `rst_ni` = 0 for one cycle together with a quarter:
  - All outputs are 0; no `exceed_o` or `refund_o` at any point.
  - Normal vend works afterwards.
- Cancel and dime in the same cycle with credit 5:
  - `refund_amt_o` = 5 and `coin_reject_o` = 1 in the same cycle.
  - `deposit_o` = 0.

Source files
------------

// File: rtl/coin_accumulator.sv
// Coin credit collector: sums nickel/dime/quarter pulses, strobes exceed_o when the
// credit reaches PRICE, and handles cancel/refund and coin rejection.
module coin_accumulator #(
  parameter int unsigned PRICE = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       nickel_i,
  input  logic       dime_i,
  input  logic       quarter_i,
  input  logic       cancel_i,
  output logic [5:0] deposit_o,
  output logic       exceed_o,
  output logic       coin_reject_o,
  output logic       refund_o,
  output logic [5:0] refund_amt_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;

  logic [1:0] state_q, state_d;
  logic [5:0] credit_q, credit_d;
  logic       exceed_q, exceed_d;
  logic       reject_q, reject_d;
  logic       refund_q, refund_d;
  logic [5:0] refund_amt_q, refund_amt_d;

  logic       any_coin;
  logic       valid_coin;
  logic [5:0] coin_val;
  logic [5:0] sum;

  assign any_coin   = nickel_i | dime_i | quarter_i;
  assign valid_coin = (nickel_i ^ dime_i ^ quarter_i) & ~(nickel_i & dime_i & quarter_i);

  always_comb begin
    coin_val = 6'd0;
    if (nickel_i)  coin_val = 6'd5;
    if (dime_i)    coin_val = 6'd10;
    if (quarter_i) coin_val = 6'd25;
  end

  // Max credit is PRICE - 5 + 25 <= 63, so the 6-bit add cannot wrap.
  assign sum = credit_q + coin_val;

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    exceed_d     = 1'b0;
    reject_d     = 1'b0;
    refund_d     = 1'b0;
    refund_amt_d = 6'd0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel_i && state_q == ST_COLLECT) begin
          refund_d     = 1'b1;
          refund_amt_d = credit_q;
          credit_d     = 6'd0;
          reject_d     = any_coin;
          state_d      = ST_IDLE;
        end else if (valid_coin) begin
          credit_d = sum;
          if (sum >= 6'(PRICE)) begin
            state_d  = ST_VEND;
            exceed_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (any_coin) begin
          reject_d = 1'b1;
        end
      end
      ST_VEND: begin
        credit_d = 6'd0;
        reject_d = any_coin;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      credit_q     <= 6'd0;
      exceed_q     <= 1'b0;
      reject_q     <= 1'b0;
      refund_q     <= 1'b0;
      refund_amt_q <= 6'd0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      exceed_q     <= exceed_d;
      reject_q     <= reject_d;
      refund_q     <= refund_d;
      refund_amt_q <= refund_amt_d;
    end
  end

  assign deposit_o     = credit_q;
  assign exceed_o      = exceed_q;
  assign coin_reject_o = reject_q;
  assign refund_o      = refund_q;
  assign refund_amt_o  = refund_amt_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator: a behavioural model pushes expected outputs per
// step into a queue; they are popped and checked one edge later.
module tb_coin_accumulator;

  localparam int unsigned PRICE = 20;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       nickel_i = 1'b0;
  logic       dime_i = 1'b0;
  logic       quarter_i = 1'b0;
  logic       cancel_i = 1'b0;
  logic [5:0] deposit_o;
  logic       exceed_o;
  logic       coin_reject_o;
  logic       refund_o;
  logic [5:0] refund_amt_o;

  typedef struct {
    int deposit;
    int exceed;
    int reject;
    int refund;
    int amt;
  } exp_t;

  exp_t exp_q[$];
  int   m_credit = 0;
  bit   m_vend = 1'b0;
  int   errors = 0;
  int   checks = 0;

  coin_accumulator #(.PRICE(PRICE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .nickel_i     (nickel_i),
    .dime_i       (dime_i),
    .quarter_i    (quarter_i),
    .cancel_i     (cancel_i),
    .deposit_o    (deposit_o),
    .exceed_o     (exceed_o),
    .coin_reject_o(coin_reject_o),
    .refund_o     (refund_o),
    .refund_amt_o (refund_amt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference behaviour for one clock edge with the given inputs.
  function automatic exp_t model(input bit r, input bit n, input bit d, input bit q,
                                 input bit c);
    exp_t e;
    int   cnt;
    e = '{deposit: 0, exceed: 0, reject: 0, refund: 0, amt: 0};
    cnt = int'(n) + int'(d) + int'(q);
    if (!r) begin
      m_credit = 0;
      m_vend   = 1'b0;
    end else if (m_vend) begin
      m_vend   = 1'b0;
      m_credit = 0;
      e.reject = (cnt > 0);
    end else if (c && m_credit > 0) begin
      e.refund = 1;
      e.amt    = m_credit;
      e.reject = (cnt > 0);
      m_credit = 0;
    end else if (cnt == 1) begin
      m_credit += n ? 5 : (d ? 10 : 25);
      if (m_credit >= int'(PRICE)) begin
        e.exceed = 1;
        m_vend   = 1'b1;
      end
      e.deposit = m_credit;
    end else begin
      e.reject  = (cnt > 1);
      e.deposit = m_credit;
    end
    return e;
  endfunction

  task automatic step(input string tag, input bit r, input bit n, input bit d, input bit q,
                      input bit c);
    exp_t e;
    exp_q.push_back(model(r, n, d, q, c));
    rst_ni    = r;
    nickel_i  = n;
    dime_i    = d;
    quarter_i = q;
    cancel_i  = c;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_deposit"}, int'(deposit_o), e.deposit);
      check({tag, "_exceed"}, int'(exceed_o), e.exceed);
      check({tag, "_reject"}, int'(coin_reject_o), e.reject);
      check({tag, "_refund"}, int'(refund_o), e.refund);
      check({tag, "_amt"}, int'(refund_amt_o), e.amt);
    end
  endtask

  initial begin
    #1;
    // Reset with a coin present: everything must stay at 0.
    step("rst0", 0, 0, 0, 1, 0);
    step("rst1", 0, 1, 0, 0, 1);

    // dime, nickel, nickel -> 10, 15, 20 (vend), then 0.
    step("a_dime", 1, 0, 1, 0, 0);
    step("a_nick1", 1, 1, 0, 0, 0);
    step("a_nick2", 1, 1, 0, 0, 0);
    check("a_vend_const_dep", int'(deposit_o), 20);
    step("a_after", 1, 0, 0, 0, 0);

    // dime, nickel, quarter -> 40 with change 20; nickel in VEND is rejected.
    step("b_dime", 1, 0, 1, 0, 0);
    step("b_nick", 1, 1, 0, 0, 0);
    step("b_quar", 1, 0, 0, 1, 0);
    check("b_change", int'(deposit_o) - int'(PRICE), 20);
    step("b_vendcoin", 1, 1, 0, 0, 0);
    check("b_reject_const", int'(coin_reject_o), 1);
    step("b_idle", 1, 0, 0, 0, 0);

    // nickel, dime, cancel -> refund 15; cancel from IDLE does nothing.
    step("c_nick", 1, 1, 0, 0, 0);
    step("c_dime", 1, 0, 1, 0, 0);
    step("c_cancel", 1, 0, 0, 0, 1);
    check("c_amt_const", int'(refund_amt_o), 15);
    step("c_cancel2", 1, 0, 0, 0, 1);

    // Double and triple coins rejected, then a single quarter vends at 25.
    step("d_double", 1, 1, 1, 0, 0);
    step("d_triple", 1, 1, 1, 1, 0);
    step("d_quar", 1, 0, 0, 1, 0);
    step("d_idle", 1, 0, 0, 0, 0);

    // Reset mid-collect with a quarter: credit discarded, no strobes.
    step("e_nick", 1, 1, 0, 0, 0);
    step("e_dime", 1, 0, 1, 0, 0);
    step("e_rst", 0, 0, 0, 1, 0);
    step("e_idle", 1, 0, 0, 0, 0);
    step("e_dime2", 1, 0, 1, 0, 0);
    step("e_dime3", 1, 0, 1, 0, 0);
    step("e_after", 1, 0, 0, 0, 0);

    // Cancel plus dime with credit 5: refund 5 and reject together.
    step("f_nick", 1, 1, 0, 0, 0);
    step("f_cancel_dime", 1, 0, 1, 0, 1);
    check("f_reject_const", int'(coin_reject_o), 1);
    step("f_idle", 1, 0, 0, 0, 0);

    // Cancel in IDLE with a coin: the coin is credited, then refunded.
    step("g_cancel_nick", 1, 1, 0, 0, 1);
    step("g_cancel", 1, 0, 0, 0, 1);
    step("g_idle", 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
